move_controller: RTL
====================

Name: move_controller

Overview:
- Upstream stage of the per-player win detectors in the TicTacToe design.
- Accepts move requests from the input/UI logic and validates them against the board occupancy.
- Alternates turns and routes each accepted cell index (0..8) to the current player's win detector as a one-cycle position code.
- Samples the detectors' win flags to declare X win, O win or draw; enforces a per-turn timeout.

Parameters:
- TIMEOUT_CYCLES, 750000000, clock cycles allowed per turn before timeout (15 s at 50 MHz); minimum 4.
- CNT_W, 30, width of the turn timer; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset; also drives the downstream win detectors.
- mov_valid  in  1  one-cycle move request strobe.
- mov_pos  in  4  requested cell, 0..8 row-major.
- gana_x  in  1  win flag from player X win detector.
- gana_o  in  1  win flag from player O win detector.
- pos_x  out  4  position code to X win detector; idle value 4'hF.
- pos_o  out  4  position code to O win detector; idle value 4'hF.
- turno  out  1  0 = X to move, 1 = O to move.
- tablero_x  out  9  cells owned by X, bit n = cell n.
- tablero_o  out  9  cells owned by O.
- mov_rechazado  out  1  one-cycle pulse: request was illegal.
- timeout  out  1  one-cycle pulse: turn timer expired.
- estado_fin  out  2  00 playing, 01 X won, 10 O won, 11 draw.

Behaviour:
- Reset values:
  - pos_x = pos_o = 4'hF.
  - turno = 0.
  - tablero_x = tablero_o = 0.
  - mov_rechazado = timeout = 0.
  - estado_fin = 00.
  - Timer = 0; state = PLAY.
- rst asserted in any state returns to these values on the next edge. A move in flight is discarded.
- FSM states:
  - PLAY: waits for a move. Timer increments each cycle.
  - COMMIT: lasts 1 cycle.
    - Sets the cell bit in the current player's tablero.
    - Drives the current player's pos_x/pos_o = cell; the other port stays 4'hF.
    - The next cycle, both ports return to 4'hF.
  - CHECK: lasts 2 cycles, covering the registered detector latency. On the last CHECK cycle gana_x/gana_o are sampled:
    - gana_x=1 -> estado_fin=01, go to DONE.
    - else gana_o=1 -> estado_fin=10, go to DONE.
    - else if all 9 cells are occupied -> estado_fin=11, go to DONE.
    - else toggle turno, clear the timer, go to PLAY.
  - DONE: holds all outputs. All inputs are ignored until rst.
- Move acceptance, in PLAY with mov_valid=1:
  - Legal when mov_pos <= 8 and the cell is free in both tableros.
  - Legal move -> COMMIT on the next edge.
  - Illegal move -> mov_rechazado pulses for the one cycle after the request. State, turno and timer are unchanged.
- mov_valid outside PLAY is ignored and does not pulse mov_rechazado.
- Timeout:
  - In PLAY, when the timer reaches TIMEOUT_CYCLES-1 with no legal move, timeout pulses for 1 cycle.
  - The timeout action follows Optional Feature.
  - A legal mov_valid in the same cycle as expiry takes priority; timeout does not pulse.
- Latency: request edge to pos_x/pos_o drive is 1 cycle. Request to estado_fin/turno update is 4 cycles.
- tablero_x and tablero_o are never both set on the same bit.

Optional Feature:
- Macro: MOVE_CONTROLLER_AUTO_MOVE_EN.
- Defined: on timeout, the controller selects the lowest-index free cell and proceeds to COMMIT exactly as for a legal request.
- Undefined: on timeout, the turn is forfeited. turno toggles, the timer clears, no cell is placed, and the state stays PLAY.

Test Plan:
- Reset, then request cell 4 -> next cycle pos_x=4 for 1 cycle, tablero_x=9'h010. Four cycles after the request, turno=1, estado_fin=00.
- X plays 4, then O requests cell 4 -> mov_rechazado pulses 1 cycle, turno stays 1, tablero_o=0. Then request mov_pos=9 -> another rejection.
- Sequence X0, O3, X1, O4, X2 -> on X2, pos_x=2 for 1 cycle, gana_x asserted by the detector, estado_fin=01. Later mov_valid is ignored.
- Sequence X0, O1, X2, O4, X3, O5, X7, O6, X8 -> no win flags, estado_fin=11, tablero_x=9'h18D, tablero_o=9'h072.
- TIMEOUT_CYCLES=8, no requests after reset:
  - With the macro defined: timeout pulse, then pos_x=0, tablero_x=9'h001, turno=1.
  - Without the macro: timeout pulse, turno=1, tablero_x=0.
- Assert rst during a CHECK state -> next cycle all outputs are at reset values, pos_x/pos_o=4'hF.

Source files
------------

// File: rtl/move_controller_if.sv
// Move-controller signal bundle between the UI/win-detector side and the controller.
// The master side issues move requests and returns the win flags; the slave side is the controller.
interface move_controller_if;
  logic       mov_valid;
  logic [3:0] mov_pos;
  logic       gana_x;
  logic       gana_o;
  logic [3:0] pos_x;
  logic [3:0] pos_o;
  logic       turno;
  logic [8:0] tablero_x;
  logic [8:0] tablero_o;
  logic       mov_rechazado;
  logic       timeout;
  logic [1:0] estado_fin;

  modport master (
    output mov_valid, mov_pos, gana_x, gana_o,
    input  pos_x, pos_o, turno, tablero_x, tablero_o, mov_rechazado, timeout, estado_fin
  );

  modport slave (
    input  mov_valid, mov_pos, gana_x, gana_o,
    output pos_x, pos_o, turno, tablero_x, tablero_o, mov_rechazado, timeout, estado_fin
  );
endinterface

// File: rtl/move_controller.sv
// TicTacToe move controller: validates moves, alternates turns, feeds the win detectors.
// Define MOVE_CONTROLLER_AUTO_MOVE_EN to auto-place on timeout instead of forfeiting the turn.
module move_controller #(
  parameter int TIMEOUT_CYCLES = 750000000,
  parameter int CNT_W          = 30
) (
  input logic               clk,
  input logic               rst,
  move_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    PLAY   = 3'd0,
    COMMIT = 3'd1,
    CHECK1 = 3'd2,
    CHECK2 = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t             r_state, w_state;
  logic [CNT_W-1:0]   r_timer, w_timer;
  logic [3:0]         r_pos_x, w_pos_x;
  logic [3:0]         r_pos_o, w_pos_o;
  logic               r_turno, w_turno;
  logic [8:0]         r_tab_x, w_tab_x;
  logic [8:0]         r_tab_o, w_tab_o;
  logic               r_rech, w_rech;
  logic               r_tmo, w_tmo;
  logic [1:0]         r_fin, w_fin;

  logic [8:0]         w_occ;
  logic [8:0]         w_req_bit;
  logic               w_legal;
  logic               w_expire;
  logic               w_commit;
  logic [3:0]         w_cell;

  assign w_occ     = r_tab_x | r_tab_o;
  // A request above 8 shifts out to zero and is caught by the range check.
  assign w_req_bit = 9'b1 << bus.mov_pos;
  assign w_legal   = bus.mov_valid && (bus.mov_pos <= 4'd8) && ((w_req_bit & w_occ) == 9'b0);
  assign w_expire  = (r_timer == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef MOVE_CONTROLLER_AUTO_MOVE_EN
  function automatic logic [3:0] lowest_free(input logic [8:0] occ);
    lowest_free = 4'hF;
    for (int i = 8; i >= 0; i--) begin
      if (!occ[i]) lowest_free = 4'(i);
    end
  endfunction

  logic [3:0] w_auto_cell;
  assign w_auto_cell = lowest_free(w_occ);
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= PLAY;
    else     r_state <= w_state;
  end

  always_comb begin
    w_state  = r_state;
    w_timer  = r_timer;
    w_pos_x  = 4'hF;
    w_pos_o  = 4'hF;
    w_turno  = r_turno;
    w_tab_x  = r_tab_x;
    w_tab_o  = r_tab_o;
    w_rech   = 1'b0;
    w_tmo    = 1'b0;
    w_fin    = r_fin;
    w_commit = 1'b0;
    w_cell   = bus.mov_pos;

    case (r_state)
      PLAY: begin
        if (w_legal) begin
          w_commit = 1'b1;
          w_state  = COMMIT;
        end else if (bus.mov_valid) begin
          w_rech = 1'b1;
        end else if (w_expire) begin
          w_tmo = 1'b1;
`ifdef MOVE_CONTROLLER_AUTO_MOVE_EN
          w_commit = 1'b1;
          w_cell   = w_auto_cell;
          w_state  = COMMIT;
`else
          w_turno = ~r_turno;
          w_timer = '0;
`endif
        end else begin
          w_timer = r_timer + CNT_W'(1);
        end
      end
      COMMIT: w_state = CHECK1;
      CHECK1: w_state = CHECK2;
      // Detector flags are registered twice after the position code, so they are valid here.
      CHECK2: begin
        if (bus.gana_x) begin
          w_fin   = 2'b01;
          w_state = DONE;
        end else if (bus.gana_o) begin
          w_fin   = 2'b10;
          w_state = DONE;
        end else if (w_occ == 9'h1FF) begin
          w_fin   = 2'b11;
          w_state = DONE;
        end else begin
          w_turno = ~r_turno;
          w_timer = '0;
          w_state = PLAY;
        end
      end
      DONE:    w_state = DONE;
      default: w_state = PLAY;
    endcase

    if (w_commit) begin
      if (!r_turno) begin
        w_pos_x = w_cell;
        w_tab_x = r_tab_x | (9'b1 << w_cell);
      end else begin
        w_pos_o = w_cell;
        w_tab_o = r_tab_o | (9'b1 << w_cell);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= '0;
      r_pos_x <= 4'hF;
      r_pos_o <= 4'hF;
      r_turno <= 1'b0;
      r_tab_x <= 9'b0;
      r_tab_o <= 9'b0;
      r_rech  <= 1'b0;
      r_tmo   <= 1'b0;
      r_fin   <= 2'b00;
    end else begin
      r_timer <= w_timer;
      r_pos_x <= w_pos_x;
      r_pos_o <= w_pos_o;
      r_turno <= w_turno;
      r_tab_x <= w_tab_x;
      r_tab_o <= w_tab_o;
      r_rech  <= w_rech;
      r_tmo   <= w_tmo;
      r_fin   <= w_fin;
    end
  end

  assign bus.pos_x         = r_pos_x;
  assign bus.pos_o         = r_pos_o;
  assign bus.turno         = r_turno;
  assign bus.tablero_x     = r_tab_x;
  assign bus.tablero_o     = r_tab_o;
  assign bus.mov_rechazado = r_rech;
  assign bus.timeout       = r_tmo;
  assign bus.estado_fin    = r_fin;

endmodule
